// File: rtl/nco_sched_pkg.sv
// Shared encodings and widths for the nco_gen job scheduler.
package nco_sched_pkg;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_ABORT = 2'd2
  } state_t;

  localparam int NCO_W    = 32;
  localparam int JOBCNT_W = 16;

endpackage

// File: rtl/nco_sched_if.sv
// Requester, completion and nco_gen config signals of the scheduler.
interface nco_sched_if #(
  parameter int NREQ = 4,
  parameter int IDW  = 2
);
  import nco_sched_pkg::*;

  logic [NREQ-1:0]       req_valid;
  logic [NREQ-1:0]       req_ready;
  logic [NREQ*NCO_W-1:0] req_start_angle;
  logic [NREQ*NCO_W-1:0] req_delta;
  logic [NREQ*NCO_W-1:0] req_length;
  logic [NREQ-1:0]       req_abort;
  logic                  done_valid;
  logic [IDW-1:0]        done_id;
  logic                  done_aborted;
  logic [NCO_W-1:0]      cfg_start_angle;
  logic [NCO_W-1:0]      cfg_delta;
  logic [NCO_W-1:0]      cfg_length;
  logic                  cfg_valid;
  logic                  cfg_ready;
  logic                  nco_reset;
  logic                  sched_busy;
  logic [JOBCNT_W-1:0]   jobs_done;

  // Scheduler side
  modport master (
    input  req_valid, req_start_angle, req_delta, req_length, req_abort, cfg_ready,
    output req_ready, done_valid, done_id, done_aborted,
    output cfg_start_angle, cfg_delta, cfg_length, cfg_valid, nco_reset, sched_busy, jobs_done
  );

  // Requester / nco_gen side
  modport slave (
    output req_valid, req_start_angle, req_delta, req_length, req_abort, cfg_ready,
    input  req_ready, done_valid, done_id, done_aborted,
    input  cfg_start_angle, cfg_delta, cfg_length, cfg_valid, nco_reset, sched_busy, jobs_done
  );
endinterface

// File: rtl/nco_rr_arb.sv
// Combinational round-robin arbiter: searches ptr+1, ptr+2, ... modulo NREQ.
module nco_rr_arb #(
  parameter int NREQ = 4,
  parameter int IDW  = 2
) (
  input  logic [NREQ-1:0] req,
  input  logic [IDW-1:0]  ptr,
  output logic [NREQ-1:0] gnt_onehot,
  output logic [IDW-1:0]  gnt_id,
  output logic            any
);

  // First requester after ptr in circular order wins
  always_comb begin
    int idx;
    idx        = 0;
    gnt_onehot = '0;
    gnt_id     = '0;
    any        = 1'b0;
    for (int i = 1; i <= NREQ; i++) begin
      idx = (int'(ptr) + i) % NREQ;
      if (!any && req[idx]) begin
        any             = 1'b1;
        gnt_id          = IDW'(idx);
        gnt_onehot[idx] = 1'b1;
      end else begin
        any = any;
      end
    end
  end

endmodule

// File: rtl/nco_sched.sv
// Round-robin scheduler sharing one nco_gen between NREQ requesters.
module nco_sched
  import nco_sched_pkg::*;
#(
  parameter int NREQ = 4,
  parameter int IDW  = 2
) (
  input  logic         clk,
  input  logic         reset_n,
  nco_sched_if.master  bus
);

  state_t              state_r;
  logic [IDW-1:0]      rr_ptr_r;
  logic [IDW-1:0]      cur_id_r;
  logic [NCO_W-1:0]    cfg_start_angle_r;
  logic [NCO_W-1:0]    cfg_delta_r;
  logic [NCO_W-1:0]    cfg_length_r;
  logic                cfg_valid_r;
  logic                nco_reset_r;
  logic                busy_r;
  logic                abort_seen_r;
  logic                done_valid_r;
  logic [IDW-1:0]      done_id_r;
  logic                done_aborted_r;
  logic [JOBCNT_W-1:0] jobs_done_r;

  logic [NREQ-1:0]     gnt_onehot_s;
  logic [IDW-1:0]      gnt_id_s;
  logic                any_s;

  nco_rr_arb #(.NREQ(NREQ), .IDW(IDW)) u_arb (
    .req        (bus.req_valid),
    .ptr        (rr_ptr_r),
    .gnt_onehot (gnt_onehot_s),
    .gnt_id     (gnt_id_s),
    .any        (any_s)
  );

  assign bus.req_ready       = (state_r == S_IDLE) ? gnt_onehot_s : {NREQ{1'b0}};
  assign bus.cfg_start_angle = cfg_start_angle_r;
  assign bus.cfg_delta       = cfg_delta_r;
  assign bus.cfg_length      = cfg_length_r;
  assign bus.cfg_valid       = cfg_valid_r;
  assign bus.nco_reset       = nco_reset_r;
  assign bus.sched_busy      = busy_r;
  assign bus.done_valid      = done_valid_r;
  assign bus.done_id         = done_id_r;
  assign bus.done_aborted    = done_aborted_r;
  assign bus.jobs_done       = jobs_done_r;

  // Job FSM with payload, completion and counter registers
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_r           <= S_IDLE;
      rr_ptr_r          <= IDW'(NREQ - 1);
      cur_id_r          <= '0;
      cfg_start_angle_r <= '0;
      cfg_delta_r       <= '0;
      cfg_length_r      <= '0;
      cfg_valid_r       <= 1'b0;
      nco_reset_r       <= 1'b0;
      busy_r            <= 1'b0;
      abort_seen_r      <= 1'b0;
      done_valid_r      <= 1'b0;
      done_id_r         <= '0;
      done_aborted_r    <= 1'b0;
      jobs_done_r       <= '0;
    end else begin
      done_valid_r <= 1'b0;
      case (state_r)
        S_IDLE: begin
          if (any_s) begin
            cfg_start_angle_r <= bus.req_start_angle[gnt_id_s*NCO_W +: NCO_W];
            cfg_delta_r       <= bus.req_delta[gnt_id_s*NCO_W +: NCO_W];
            cfg_length_r      <= bus.req_length[gnt_id_s*NCO_W +: NCO_W];
            cur_id_r          <= gnt_id_s;
            rr_ptr_r          <= gnt_id_s;
            cfg_valid_r       <= 1'b1;
            busy_r            <= 1'b1;
            abort_seen_r      <= 1'b0;
            state_r           <= S_ISSUE;
          end else begin
            cfg_valid_r <= 1'b0;
          end
        end
        S_ISSUE: begin
          // Completion wins over a same-cycle abort
          if (bus.cfg_ready) begin
            done_valid_r   <= 1'b1;
            done_id_r      <= cur_id_r;
            done_aborted_r <= abort_seen_r;
            jobs_done_r    <= jobs_done_r + 16'd1;
            cfg_valid_r    <= 1'b0;
            busy_r         <= 1'b0;
            state_r        <= S_IDLE;
          end else if (bus.req_abort[cur_id_r]) begin
            abort_seen_r <= 1'b1;
            nco_reset_r  <= 1'b1;
            state_r      <= S_ABORT;
          end else begin
            state_r <= S_ISSUE;
          end
        end
        S_ABORT: begin
          if (bus.cfg_ready) begin
            done_valid_r   <= 1'b1;
            done_id_r      <= cur_id_r;
            done_aborted_r <= 1'b1;
            jobs_done_r    <= jobs_done_r + 16'd1;
            cfg_valid_r    <= 1'b0;
            nco_reset_r    <= 1'b0;
            busy_r         <= 1'b0;
            abort_seen_r   <= 1'b0;
            state_r        <= S_IDLE;
          end else begin
            state_r <= S_ABORT;
          end
        end
        default: begin
          cfg_valid_r <= 1'b0;
          nco_reset_r <= 1'b0;
          busy_r      <= 1'b0;
          state_r     <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_nco_sched.sv
// Scoreboard bench for nco_sched: grants and done records are queued when driven.
module tb_nco_sched;

  typedef struct packed {
    logic [1:0]  id;
    logic        aborted;
    logic [15:0] cnt;
  } done_rec_t;

  logic clk;
  logic reset_n;
  int   checks;
  int   errors;
  int   jobs_exp;

  logic [3:0] gnt_q[$];
  done_rec_t  done_q[$];

  nco_sched_if #(.NREQ(4), .IDW(2)) bus ();

  nco_sched #(.NREQ(4), .IDW(2)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: observed %0h, expected %0h", tag, got, exp);
    end
  endtask

  task automatic set_payload(input int id, input logic [31:0] sa, input logic [31:0] dl,
                             input logic [31:0] len);
    bus.req_start_angle[id*32 +: 32] = sa;
    bus.req_delta[id*32 +: 32]       = dl;
    bus.req_length[id*32 +: 32]      = len;
  endtask

  task automatic push_done(input int id, input logic ab);
    done_rec_t rec;
    jobs_exp++;
    rec.id      = 2'(id);
    rec.aborted = ab;
    rec.cnt     = 16'(jobs_exp);
    done_q.push_back(rec);
  endtask

  // One job from a single requester; called at posedge+1 in IDLE, returns likewise
  task automatic do_job(input int id, input logic [31:0] len, input logic [31:0] dl,
                        input int ready_cycles, input int abort_cycle);
    logic [31:0] sa;
    logic        ab;
    sa = 32'hA000_0000 | 32'(id);
    ab = (abort_cycle >= 0) && (abort_cycle < ready_cycles - 1);
    set_payload(id, sa, dl, len);
    bus.req_valid[id] = 1'b1;
    gnt_q.push_back(4'b0001 << id);
    @(posedge clk); #1;
    bus.req_valid[id] = 1'b0;
    check_val("cfg_valid_issue", 32'(bus.cfg_valid), 32'd1);
    check_val("cfg_start_angle", bus.cfg_start_angle, sa);
    check_val("cfg_length", bus.cfg_length, len);
    for (int n = 0; n < ready_cycles; n++) begin
      check_val("cfg_delta_hold", bus.cfg_delta, dl);
      check_val("nco_reset_run", 32'(bus.nco_reset), 32'(ab && (n > abort_cycle)));
      if (n == abort_cycle) bus.req_abort[id] = 1'b1;
      if (n == ready_cycles - 1) begin
        bus.cfg_ready = 1'b1;
        push_done(id, ab);
      end
      @(posedge clk); #1;
    end
    bus.cfg_ready     = 1'b0;
    bus.req_abort[id] = 1'b0;
    check_val("cfg_valid_end", 32'(bus.cfg_valid), 32'd0);
    check_val("nco_reset_end", 32'(bus.nco_reset), 32'd0);
    check_val("busy_end", 32'(bus.sched_busy), 32'd0);
  endtask

  // Output monitor: grants and completions are popped from the scoreboard
  always @(negedge clk) begin
    if (bus.req_ready != 4'b0000) begin
      check_val("ready_only_idle", 32'(bus.sched_busy), 32'd0);
      if (gnt_q.size() == 0) check_val("gnt_unexpected", 32'(bus.req_ready), 32'd0);
      else check_val("gnt", 32'(bus.req_ready), 32'(gnt_q.pop_front()));
    end
    if (bus.done_valid) begin
      if (done_q.size() == 0) begin
        check_val("done_unexpected", 32'(bus.done_valid), 32'd0);
      end else begin
        done_rec_t rec;
        rec = done_q.pop_front();
        check_val("done_id", 32'(bus.done_id), 32'(rec.id));
        check_val("done_aborted", 32'(bus.done_aborted), 32'(rec.aborted));
        check_val("jobs_done", 32'(bus.jobs_done), 32'(rec.cnt));
      end
    end
  end

  initial begin
    clk                 = 1'b0;
    reset_n             = 1'b0;
    checks              = 0;
    errors              = 0;
    jobs_exp            = 0;
    bus.req_valid       = '0;
    bus.req_abort       = '0;
    bus.req_start_angle = '0;
    bus.req_delta       = '0;
    bus.req_length      = '0;
    bus.cfg_ready       = 1'b0;
    #2;
    check_val("rst_cfg_valid", 32'(bus.cfg_valid), 32'd0);
    check_val("rst_busy", 32'(bus.sched_busy), 32'd0);
    check_val("rst_jobs", 32'(bus.jobs_done), 32'd0);
    check_val("rst_done", 32'(bus.done_valid), 32'd0);
    check_val("rst_nco_reset", 32'(bus.nco_reset), 32'd0);
    check_val("rst_cfg_delta", bus.cfg_delta, 32'd0);
    @(posedge clk); @(posedge clk); #1;
    reset_n = 1'b1;
    @(posedge clk); #1;

    // Single job: length 4, delta 0x100
    do_job(0, 32'd4, 32'h100, 4, -1);

    // Fairness: all four held valid; rr_ptr is now 0, so rotation starts at 1
    for (int k = 0; k < 4; k++) set_payload(k, 32'hB000_0000 | 32'(k), 32'h10 * 32'(k), 32'd2);
    bus.req_valid = 4'b1111;
    for (int j = 0; j < 8; j++) begin
      check_val("idle_gap", 32'(bus.sched_busy), 32'd0);
      gnt_q.push_back(4'b0001 << ((j + 1) % 4));
      @(posedge clk); #1;
      check_val("fair_payload", bus.cfg_start_angle, 32'hB000_0000 | 32'((j + 1) % 4));
      bus.cfg_ready = 1'b1;
      push_done((j + 1) % 4, 1'b0);
      @(posedge clk); #1;
      bus.cfg_ready = 1'b0;
    end
    bus.req_valid = 4'b0000;
    @(posedge clk); #1;

    // Abort of req2 at ISSUE cycle 10, nco_gen answers at cycle 13
    do_job(2, 32'd1000, 32'h200, 14, 10);
    // Zero-length job
    do_job(1, 32'd0, 32'h300, 1, -1);
    // Abort coincident with cfg_ready
    do_job(0, 32'd8, 32'h400, 3, 2);
    // Abort from a non-granted requester, also held through IDLE
    bus.req_abort[3] = 1'b1;
    @(posedge clk); #1;
    do_job(0, 32'd8, 32'h500, 3, -1);
    bus.req_abort[3] = 1'b0;

    // Reset mid-job, then all four valid: req0 must win
    set_payload(2, 32'hC000_0002, 32'h600, 32'd50);
    bus.req_valid[2] = 1'b1;
    gnt_q.push_back(4'b0100);
    @(posedge clk); #1;
    bus.req_valid[2] = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    reset_n = 1'b0;
    #1;
    check_val("midrst_cfg_valid", 32'(bus.cfg_valid), 32'd0);
    check_val("midrst_busy", 32'(bus.sched_busy), 32'd0);
    check_val("midrst_jobs", 32'(bus.jobs_done), 32'd0);
    check_val("midrst_cfg_delta", bus.cfg_delta, 32'd0);
    jobs_exp = 0;
    @(posedge clk); @(posedge clk); #1;
    reset_n = 1'b1;
    for (int k = 0; k < 4; k++) set_payload(k, 32'hD000_0000 | 32'(k), 32'h700, 32'd3);
    bus.req_valid = 4'b1111;
    gnt_q.push_back(4'b0001);
    @(posedge clk); #1;
    bus.req_valid = 4'b0000;
    check_val("post_rst_winner", bus.cfg_start_angle, 32'hD000_0000);
    bus.cfg_ready = 1'b1;
    push_done(0, 1'b0);
    @(posedge clk); #1;
    bus.cfg_ready = 1'b0;

    repeat (3) @(posedge clk);
    #1;
    check_val("gnt_q_drained", 32'(gnt_q.size()), 32'd0);
    check_val("done_q_drained", 32'(done_q.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
